// File: rtl/l1c_inst_assoc.sv
// l1c_inst_assoc -- set-associative L1 instruction cache.
//
// Sits between the core fetch port and the CPU wrapper (M0 read channel).
// WAYS-way, NUM_SETS sets, LINE_WORDS 32-bit words per line, round-robin
// replacement per set, whole-cache flush. Read-only. The fetch port is
// yielded to L1D while l1d_busy is high.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   core_addr/req     fetch byte address / request
//   core_out/wait     fetched instruction / stall to core
//   I_req/I_addr      refill beat request / word address of current beat
//   I_out             refill beat data
//   read_data_valid   refill beat accepted this cycle
//   l1d_busy          L1D owns the memory port; no new lookup accepted
//   flush             invalidate all lines (level)
//   l1i_state         FSM state code (IDLE=0 LOOKUP=1 REFILL=2 FLUSH=3)
//
// Optional build macro L1I_PERF_CNT_EN: adds saturating hit_cnt / miss_cnt
// outputs. With the macro undefined the counters and ports are absent.

// One way of the cache: valid bits, tags and line data for every set.
// All accesses use the single set index of the request in flight.
module l1c_inst_assoc_way #(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(NUM_SETS),
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = 30 - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [OFF_W-1:0] rd_word,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             inv_en,
  input  logic             fill_en,
  input  logic             flush_all,
  output logic             hit,
  output logic             valid,
  output logic [31:0]      rd_data
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           valid_q <= '0;
    else if (flush_all) valid_q <= '0;
    else if (inv_en)    valid_q[idx] <= 1'b0;
    else if (fill_en)   valid_q[idx] <= 1'b1;
  end

  // Tag and data need no reset: they are only trusted behind valid.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[idx] <= tag_in;
    if (wr_en)   data_q[idx][wr_word] <= wr_data;
  end

  assign valid   = valid_q[idx];
  assign hit     = valid & (tag_q[idx] == tag_in);
  assign rd_data = data_q[idx][rd_word];
endmodule

module l1c_inst_assoc #(
  parameter int WAYS       = 2,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic        core_req,
  output logic [31:0] core_out,
  output logic        core_wait,
  output logic        I_req,
  output logic [31:0] I_addr,
  input  logic [31:0] I_out,
  input  logic        read_data_valid,
  input  logic        l1d_busy,
  input  logic        flush,
  output logic [2:0]  l1i_state
`ifdef L1I_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  // A 1-way cache still carries a 1-bit pointer; it is held at 0.
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REFILL = 3'd2,
    S_FLUSH  = 3'd3
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] word;
  } fetch_addr_t;

  state_t                         state;
  fetch_addr_t                    addr_reg;
  logic [OFF_W-1:0]               beat;
  logic [RR_W-1:0]                victim;
  logic                           victim_rr;   // victim came from rr pointer
  logic                           flush_pend;  // flush seen while busy
  logic [NUM_SETS-1:0][RR_W-1:0]  rr_q;

  logic [WAYS-1:0]                hit_vec, valid_vec;
  logic [WAYS-1:0][31:0]          word_vec;
  logic [WAYS-1:0]                wr_en, inv_en, fill_en;
  logic                           any_hit, last_beat, refill_beat;
  logic [31:0]                    hit_word;
  logic [RR_W-1:0]                pick_way;
  logic                           pick_rr;
  logic                           unused_addr_lsb;

  assign unused_addr_lsb = ^core_addr[1:0];

  assign refill_beat = (state == S_REFILL) & read_data_valid;
  assign last_beat   = refill_beat & (beat == OFF_W'(LINE_WORDS - 1));

  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_way
      assign wr_en[gw]   = refill_beat & (victim == RR_W'(gw));
      assign fill_en[gw] = last_beat & (victim == RR_W'(gw));
      // Victim is invalidated as the refill starts so a partial line never hits.
      assign inv_en[gw]  = (state == S_LOOKUP) & ~any_hit & (pick_way == RR_W'(gw));

      l1c_inst_assoc_way #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
      ) u_way (
        .clk       (clk),
        .rst       (rst),
        .idx       (addr_reg.idx),
        .tag_in    (addr_reg.tag),
        .rd_word   (addr_reg.word),
        .wr_en     (wr_en[gw]),
        .wr_word   (beat),
        .wr_data   (I_out),
        .inv_en    (inv_en[gw]),
        .fill_en   (fill_en[gw]),
        .flush_all (state == S_FLUSH),
        .hit       (hit_vec[gw]),
        .valid     (valid_vec[gw]),
        .rd_data   (word_vec[gw])
      );
    end
  endgenerate

  assign any_hit = |hit_vec;

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_word = word_vec[w];
  end

  // Lowest-numbered invalid way wins (descending loop overwrites); if the
  // whole set is valid the per-set round-robin pointer picks the victim.
  always_comb begin
    pick_way = rr_q[addr_reg.idx];
    pick_rr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_vec[w]) begin
        pick_way = RR_W'(w);
        pick_rr  = 1'b0;
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      beat       <= '0;
      victim     <= '0;
      victim_rr  <= 1'b0;
      flush_pend <= 1'b0;
      core_out   <= '0;
      rr_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush | flush_pend) begin
            state <= S_FLUSH;
          end else if (core_req & ~l1d_busy) begin
            addr_reg <= fetch_addr_t'(core_addr[31:2]);
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          flush_pend <= flush_pend | flush;
          if (any_hit) begin
            core_out <= hit_word;
            state    <= S_IDLE;
          end else begin
            victim    <= pick_way;
            victim_rr <= pick_rr;
            beat      <= '0;
            state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          flush_pend <= flush_pend | flush;
          if (read_data_valid) begin
            if (last_beat) begin
              // Requested word is either this beat or already stored.
              core_out <= (addr_reg.word == beat) ? I_out : word_vec[victim];
              if (victim_rr)
                rr_q[addr_reg.idx] <= (WAYS == 1) ? '0 : rr_q[addr_reg.idx] + RR_W'(1);
              beat  <= '0;
              state <= S_IDLE;
            end else begin
              beat <= beat + OFF_W'(1);
            end
          end
        end
        S_FLUSH: begin
          rr_q       <= '0;
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_wait = 1'b1;
    if (state == S_IDLE) core_wait = core_req & (l1d_busy | flush | flush_pend);
  end

  assign I_req     = (state == S_REFILL);
  assign I_addr    = (state == S_REFILL) ? {addr_reg.tag, addr_reg.idx, beat, 2'b00} : '0;
  assign l1i_state = state;

`ifdef L1I_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (any_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_l1c_inst_assoc.sv
// Directed bench for l1c_inst_assoc: a memory responder with configurable
// per-beat wait, a queue of expected fetch data pushed at request time and
// popped when the cache returns to IDLE, and immediate assertions at each
// comparison.
module tb_l1c_inst_assoc;
  logic        clk, rst;
  logic [31:0] core_addr, core_out, I_addr, I_out;
  logic        core_req, core_wait, I_req, read_data_valid, l1d_busy, flush;
  logic [2:0]  l1i_state;
`ifdef L1I_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int beats = 0;
  int bbase = 0;
  int abase = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addrs[$];

  l1c_inst_assoc dut (
    .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req),
    .core_out(core_out), .core_wait(core_wait), .I_req(I_req), .I_addr(I_addr),
    .I_out(I_out), .read_data_valid(read_data_valid), .l1d_busy(l1d_busy),
    .flush(flush), .l1i_state(l1i_state)
`ifdef L1I_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory side: presents a beat after mem_wait idle cycles; outside a
  // refill it toggles read_data_valid randomly, which must be ignored.
  initial begin
    int wcnt;
    wcnt = 0;
    read_data_valid = 1'b0;
    I_out = '0;
    forever begin
      @(negedge clk);
      if (I_req && rst) begin
        if (wcnt == mem_wait) begin
          read_data_valid = 1'b1;
          I_out = memf(I_addr);
          beats++;
          addrs.push_back(I_addr);
          wcnt = 0;
        end else begin
          read_data_valid = 1'b0;
          I_out = $urandom;
          wcnt++;
        end
      end else begin
        read_data_valid = 1'($urandom_range(0, 1));
        I_out = $urandom;
        wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle (assumes IDLE and not busy), then
  // scramble core_addr so a late capture would be visible.
  task automatic issue(input logic [31:0] a);
    @(negedge clk);
    core_addr = a;
    core_req  = 1'b1;
    exp_q.push_back(memf({a[31:2], 2'b00}));
    bbase = beats;
    abase = addrs.size();
    @(posedge clk);
    @(negedge clk);
    core_req  = 1'b0;
    core_addr = 32'hDEAD_BEE0;
  endtask

  // Wait (bounded) for the response; exp_lat counts edges from acceptance,
  // 0 skips the latency comparison.
  task automatic finish(input string tag, input int exp_beats, input int exp_lat);
    int n;
    n = 1;
    while (!(l1i_state == 3'd0 && !core_wait) && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_done"}, {29'd0, l1i_state}, 32'd0);
    check({tag, "_data"}, core_out, exp_q.pop_front());
    if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
    check({tag, "_beats"}, beats - bbase, exp_beats);
  endtask

  initial begin
    int k;
    rst = 1'b0; core_addr = '0; core_req = 1'b0; l1d_busy = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, l1i_state}, 32'd0);
    check("rst_core_out", core_out, 32'd0);
    check("rst_core_wait", {31'd0, core_wait}, 32'd0);
    check("rst_I_req", {31'd0, I_req}, 32'd0);
    check("rst_I_addr", I_addr, 32'd0);
    rst = 1'b1;

    // Cold miss, zero-wait memory: 2 + 4 cycles, word 2 returned.
    mem_wait = 0;
    issue(32'h0000_1008);
    finish("cold", 4, 6);
    for (int i = 0; i < 4; i++)
      check("cold_I_addr", addrs[abase + i], 32'h0000_1000 + 32'(4 * i));

    issue(32'h0000_100C);
    finish("hit_100c", 0, 2);

    // Same-set conflicts with one wait cycle per beat: 2 + 4 + 4.
    mem_wait = 1;
    issue(32'h0000_2000); finish("fill_2000", 4, 10);
    issue(32'h0000_3000); finish("fill_3000", 4, 10);   // evicts way0 (0x1000)
    issue(32'h0000_2000); finish("hit_2000", 0, 2);
    issue(32'h0000_1000); finish("miss_1000", 4, 10);   // evicts way1 (0x2000)
    issue(32'h0000_3000); finish("hit_3000", 0, 2);
    issue(32'h0000_2000); finish("miss_2000", 4, 10);   // evicts way0 (0x3000)

    // l1d_busy holds off acceptance.
    @(negedge clk);
    core_addr = 32'h0000_100C; core_req = 1'b1; l1d_busy = 1'b1;
    exp_q.push_back(memf(32'h0000_100C));
    bbase = beats;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("busy_state", {29'd0, l1i_state}, 32'd0);
    check("busy_wait", {31'd0, core_wait}, 32'd1);
    l1d_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    core_req = 1'b0; core_addr = 32'hDEAD_BEE0;
    check("busy_release", {29'd0, l1i_state}, 32'd1);
    finish("busy_hit", 0, 2);

    // Flush pulse during refill: refill completes, then one FLUSH cycle.
    mem_wait = 0;
    issue(32'h0000_4010);
    k = 0;
    while (l1i_state != 3'd2 && k < 20) begin @(posedge clk); k++; @(negedge clk); end
    check("flush_saw_refill", {29'd0, l1i_state}, 32'd2);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    finish("flush_refill", 4, 0);
    @(posedge clk); @(negedge clk);
    check("flush_state", {29'd0, l1i_state}, 32'd3);
    check("flush_wait", {31'd0, core_wait}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("flush_back_idle", {29'd0, l1i_state}, 32'd0);
    issue(32'h0000_4010); finish("post_flush", 4, 6);
    issue(32'h0000_1000); finish("post_flush_1000", 4, 6);

    // Reset in the middle of a refill.
    issue(32'h0000_5020);
    k = 0;
    while ((beats - bbase) < 3 && k < 50) begin @(posedge clk); k++; @(negedge clk); end
    check("midrst_beats", beats - bbase, 3);
    rst = 1'b0;
    #1;
    check("midrst_I_req", {31'd0, I_req}, 32'd0);
    check("midrst_I_addr", I_addr, 32'd0);
    check("midrst_state", {29'd0, l1i_state}, 32'd0);
    check("midrst_core_out", core_out, 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    issue(32'h0000_5020); finish("post_rst", 4, 6);
    issue(32'h0000_5024); finish("post_rst_hit", 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
